// File: rtl/stream_capture.sv
// Capture endpoint for a ready/valid sample stream: stores a software-armed burst
// in a block-RAM buffer and tracks the sample count and peak magnitude.
`timescale 1ns/1ps
module stream_capture #(
    parameter type out_t = logic signed [15:0],
    parameter int  DEPTH = 64,
    parameter int  CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [$bits(out_t)-1:0]    s_data,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_samples,
    input  logic                       abort,
    input  logic                       hold,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [CNT_W-1:0]           captured,
    output logic [$bits(out_t)-1:0]    peak_abs,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [$bits(out_t)-1:0]    rd_data
);

    localparam int W  = $bits(out_t);
    localparam int AW = $clog2(DEPTH);

    localparam logic [W-1:0]     MOST_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     MOST_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] captured_q, captured_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [W-1:0]     peak_q, peak_d;
    logic             err_q, err_d;
    logic [W-1:0]     rd_data_q;
    logic [W-1:0]     mem [DEPTH];

    logic             xfer;
    logic             len_ok;
    logic [W-1:0]     mag;

    // Ready depends only on registered state and hold, never on s_valid.
    assign s_ready = (state_q == CAPTURE) && !hold;
    assign xfer    = s_valid && s_ready;
    assign len_ok  = (num_samples != '0) && (num_samples <= DEPTH_CNT);

    // Magnitude with the most-negative code clamped so it fits in W bits.
    always_comb begin
        mag = s_data;
        if (s_data == MOST_NEG) begin
            mag = MOST_POS;
        end else if (s_data[W-1]) begin
            mag = -s_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        captured_d = captured_q;
        wr_ptr_d   = wr_ptr_q;
        peak_d     = peak_q;
        err_d      = err_q;

        // A transfer is always committed, even when abort lands in the same cycle.
        if (xfer) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            captured_d = captured_q + CNT_W'(1);
            if (mag > peak_q) begin
                peak_d = mag;
            end
        end

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (len_ok) begin
                            state_d    = CAPTURE;
                            len_d      = num_samples;
                            wr_ptr_d   = '0;
                            captured_d = '0;
                            peak_d     = '0;
                            err_d      = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (xfer && (captured_q + CNT_W'(1) == len_q)) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            captured_q <= '0;
            wr_ptr_q   <= '0;
            peak_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            captured_q <= captured_d;
            wr_ptr_q   <= wr_ptr_d;
            peak_q     <= peak_d;
            err_q      <= err_d;
        end
    end

    // Buffer array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    // Registered read; a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign busy     = (state_q == CAPTURE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign captured = captured_q;
    assign peak_abs = peak_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_stream_capture.sv
// Table-driven bench for stream_capture with a scoreboard of written samples
// that is drained through the registered read port.
`timescale 1ns/1ps
module tb_stream_capture;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;
    localparam int W     = 16;
    localparam int AW    = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             abort;
    logic             hold;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] captured;
    logic [W-1:0]     peak_abs;
    logic [AW-1:0]    rd_addr;
    logic [W-1:0]     rd_data;

    stream_capture #(
        .out_t (logic signed [15:0]),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .start       (start),
        .num_samples (num_samples),
        .abort       (abort),
        .hold        (hold),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .captured    (captured),
        .peak_abs    (peak_abs),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [W-1:0]     data;
        logic             hold;
        logic             exp_ready;
        logic [CNT_W-1:0] exp_cap;
        logic [W-1:0]     exp_peak;
        logic             exp_done;
    } vec_t;

    vec_t         tbl [128];
    int           n_vec;
    logic [W-1:0] sb [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    // Reference model of the burst in progress
    logic [CNT_W-1:0] m_len, m_cap;
    logic [W-1:0]     m_peak;
    logic             m_busy, m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mag_of(input logic [W-1:0] x);
        if (x == 16'h8000) return 16'h7fff;
        return x[W-1] ? (~x + 16'd1) : x;
    endfunction

    function automatic void model_start(input int len);
        m_len  = CNT_W'(len);
        m_cap  = '0;
        m_peak = '0;
        m_busy = 1'b1;
        m_done = 1'b0;
        n_vec  = 0;
        sb.delete();
    endfunction

    function automatic void add_step(input logic valid, input logic [W-1:0] data, input logic hld);
        logic rdy;
        rdy = m_busy && !hld;
        if (valid && rdy) begin
            m_cap = m_cap + 1'b1;
            if (mag_of(data) > m_peak) m_peak = mag_of(data);
            if (m_cap == m_len) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        tbl[n_vec] = '{valid, data, hld, rdy, m_cap, m_peak, m_done};
        n_vec++;
    endfunction

    task automatic do_start(input int n);
        start       = 1'b1;
        num_samples = CNT_W'(n);
        tick();
        start       = 1'b0;
        num_samples = '0;
    endtask

    task automatic run_table();
        for (int i = 0; i < n_vec; i++) begin
            s_valid = tbl[i].valid;
            s_data  = tbl[i].data;
            hold    = tbl[i].hold;
            #1;
            check("s_ready", s_ready, tbl[i].exp_ready);
            if (tbl[i].valid && tbl[i].exp_ready) begin
                sb.push_back(tbl[i].data);
                $display("xfer %0d data %h", sb.size() - 1, tbl[i].data);
            end
            tick();
            check("captured", captured, tbl[i].exp_cap);
            check("peak_abs", peak_abs, tbl[i].exp_peak);
            check("done", done, tbl[i].exp_done);
        end
        s_valid = 1'b0;
        hold    = 1'b0;
    endtask

    task automatic read_all(input int n);
        logic [W-1:0] exp;
        check("sb_count", sb.size(), n);
        for (int a = 0; a < n && sb.size() > 0; a++) begin
            rd_addr = AW'(a);
            tick();
            exp = sb.pop_front();
            check("rd_data", rd_data, exp);
            $display("read addr %0d data %h", a, rd_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        logic [W-1:0] v;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; start = 1'b0;
        num_samples = '0; abort = 1'b0; hold = 1'b0; rd_addr = '0;
        tick(); tick();
        check("rst_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_captured", captured, 0);
        check("rst_peak", peak_abs, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Bad lengths
        do_start(0);
        check("bad0_err", err, 1);
        check("bad0_busy", busy, 0);
        check("bad0_ready", s_ready, 0);
        do_start(DEPTH + 1);
        check("bad65_err", err, 1);
        check("bad65_busy", busy, 0);
        check("bad65_ready", s_ready, 0);

        // Basic burst
        do_start(4);
        check("basic_err_clr", err, 0);
        check("basic_busy", busy, 1);
        check("basic_ready", s_ready, 1);
        model_start(4);
        add_step(1'b1, 16'd10, 1'b0);
        add_step(1'b1, 16'hfffd, 1'b0);
        add_step(1'b1, 16'd7, 1'b0);
        add_step(1'b1, 16'd2, 1'b0);
        add_step(1'b0, 16'd0, 1'b0);
        run_table();
        check("basic_captured", captured, 4);
        check("basic_peak", peak_abs, 10);
        check("basic_done", done, 1);
        read_all(4);

        // Backpressure: hold toggles, payload advances only when accepted
        do_start(8);
        model_start(8);
        v = 16'd100;
        c = 0;
        while (!m_done && c < 40) begin
            add_step(1'b1, v, c[0]);
            if (!c[0]) v = v + 16'd1;
            c++;
        end
        add_step(1'b0, 16'd0, 1'b0);
        run_table();
        check("bp_captured", captured, 8);
        read_all(8);

        // Peak saturation
        do_start(1);
        model_start(1);
        add_step(1'b1, 16'h8000, 1'b0);
        add_step(1'b0, 16'd0, 1'b0);
        run_table();
        check("sat_peak", peak_abs, 16'h7fff);
        check("sat_done", done, 1);

        // Abort after 3 of 10, with start in the same cycle
        do_start(10);
        model_start(10);
        add_step(1'b1, 16'd5, 1'b0);
        add_step(1'b1, 16'hfff0, 1'b0);
        add_step(1'b1, 16'd9, 1'b0);
        run_table();
        abort = 1'b1; start = 1'b1; num_samples = CNT_W'(5);
        tick();
        abort = 1'b0; start = 1'b0; num_samples = '0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_captured", captured, 3);
        check("abort_peak", peak_abs, 16);
        check("abort_ready", s_ready, 0);
        tick();
        check("abort_start_ignored", busy, 0);

        // Full depth with occasional hold
        do_start(DEPTH);
        model_start(DEPTH);
        c = 0;
        while (!m_done && c < 120) begin
            add_step(1'b1, W'(c * 1237 + 91), (c % 5) == 3);
            c++;
        end
        add_step(1'b0, 16'd0, 1'b0);
        run_table();
        check("full_captured", captured, DEPTH);
        check("full_done", done, 1);
        read_all(DEPTH);

        // Asynchronous reset mid-burst
        do_start(10);
        model_start(10);
        add_step(1'b1, 16'h1234, 1'b0);
        add_step(1'b1, 16'h0abc, 1'b0);
        run_table();
        rd_addr = AW'(1);
        tick();
        check("pre_rst_rd_data", rd_data, 16'h0abc);
        check("pre_rst_busy", busy, 1);
        s_valid = 1'b1;
        s_data  = 16'h7777;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_captured", captured, 0);
        check("arst_peak", peak_abs, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_ready", s_ready, 0);
        s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
